zeroheti_addr_demux: RTL

Parametrised address-decoding bus demultiplexer between the zeroHETI core data port and `NumRules` memory-mapped targets (debug, IMEM, DMEM, CLIC, external, and any added later). It replaces fixed per-region decode with a rule table. It tracks outstanding transactions so responses return to the core in order. It also terminates unmapped accesses with an internal error response.

---
 rtl/zeroheti_pkg.sv | 27 ++
 rtl/zeroheti_addr_decode.sv | 31 +++
 rtl/zeroheti_addr_demux.sv | 129 ++++++++++++
 3 files changed

// File: rtl/zeroheti_pkg.sv
// Shared address-map types and the default zeroHETI data-port memory map.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  localparam int AddrMapRules = 5;
  typedef addr_rule_t [AddrMapRules-1:0] addr_map_t;

  // Index 0 sits in the LSBs: dbg, imem, dmem, clic, ext.
  localparam addr_map_t AddrMap = {
    addr_rule_t'{base: 32'h0001_0000, last: 32'hFFFF_FFFF},
    addr_rule_t'{base: 32'h0000_9000, last: 32'h0000_A000},
    addr_rule_t'{base: 32'h0000_5000, last: 32'h0000_9000},
    addr_rule_t'{base: 32'h0000_1000, last: 32'h0000_5000},
    addr_rule_t'{base: 32'h0000_0000, last: 32'h0000_1000}
  };

  // An all-ones last address also covers the top byte of the address space.
  function automatic logic rule_hit(input addr_rule_t rule, input logic [31:0] addr);
    return (addr >= rule.base) &&
           ((addr < rule.last) || ((rule.last == '1) && (addr == '1)));
  endfunction

endpackage

// File: rtl/zeroheti_addr_decode.sv
// Combinational rule-table match; the lowest matching rule index wins.
module zeroheti_addr_decode
  import zeroheti_pkg::*;
#(
  parameter int                        NumRules = 5,
  parameter int                        IdxW     = $clog2(NumRules + 1),
  parameter addr_rule_t [NumRules-1:0] Rules    = AddrMap
) (
  input  logic [31:0]     addr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            hit_o
);

  logic [NumRules-1:0] match;

  for (genvar gi = 0; gi < NumRules; gi++) begin : g_match
    assign match[gi] = rule_hit(Rules[gi], addr_i);
  end

  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx_o = IdxW'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zeroheti_addr_demux.sv
// Core data-port demux: rule decode, same-target issue with in-order stall, miss responder.
module zeroheti_addr_demux
  import zeroheti_pkg::*;
#(
  parameter int                        NumRules = 5,
  parameter int                        MaxTrans = 2,
  parameter addr_rule_t [NumRules-1:0] Rules    = AddrMap
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [31:0]              addr_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic [NumRules-1:0]      tgt_req_o,
  input  logic [NumRules-1:0]      tgt_gnt_i,
  output logic [31:0]              tgt_addr_o,
  output logic                     tgt_we_o,
  output logic [3:0]               tgt_be_o,
  output logic [31:0]              tgt_wdata_o,
  input  logic [NumRules-1:0]      tgt_rvalid_i,
  input  logic [NumRules-1:0][31:0] tgt_rdata_i,
  input  logic [NumRules-1:0]      tgt_err_i
);

  localparam int SelW = $clog2(NumRules + 1);
  localparam int CntW = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] SelErr = SelW'(NumRules);

  logic [SelW-1:0] dec_idx;
  logic            dec_hit;
  logic [SelW-1:0] sel;
  logic [SelW-1:0] sel_q;
  logic [CntW-1:0] cnt_q;
  logic            err_pend_q;
  logic            issue_ok;
  logic            err_retire;
  logic            err_slot_ok;

  zeroheti_addr_decode #(
    .NumRules (NumRules),
    .IdxW     (SelW),
    .Rules    (Rules)
  ) u_decode (
    .addr_i (addr_i),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit)
  );

  assign sel         = dec_hit ? dec_idx : SelErr;
  assign err_retire  = err_pend_q && (cnt_q != '0) && (sel_q == SelErr);
  assign err_slot_ok = !err_pend_q || err_retire;
  // Only one target may own the outstanding window, which keeps responses ordered.
  assign issue_ok    = req_i && (cnt_q < CntW'(MaxTrans)) &&
                       ((cnt_q == '0) || (sel == sel_q));

  assign tgt_addr_o  = addr_i;
  assign tgt_we_o    = we_i;
  assign tgt_be_o    = be_i;
  assign tgt_wdata_o = wdata_i;

  always_comb begin
    tgt_req_o = '0;
    gnt_o     = 1'b0;
    rvalid_o  = 1'b0;
    rdata_o   = '0;
    err_o     = 1'b0;
    if (issue_ok) begin
      if (!dec_hit) begin
        gnt_o = err_slot_ok;
      end else begin
        for (int i = 0; i < NumRules; i++) begin
          if (sel == SelW'(i)) begin
            tgt_req_o[i] = 1'b1;
            gnt_o        = tgt_gnt_i[i];
          end
        end
      end
    end
    if (cnt_q != '0) begin
      if (sel_q == SelErr) begin
        rvalid_o = err_pend_q;
        err_o    = err_pend_q;
      end else begin
        for (int i = 0; i < NumRules; i++) begin
          if ((sel_q == SelW'(i)) && tgt_rvalid_i[i]) begin
            rvalid_o = 1'b1;
            rdata_o  = tgt_rdata_i[i];
            err_o    = tgt_err_i[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      case ({gnt_o, rvalid_o})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (gnt_o) begin
        sel_q <= sel;
      end
      err_pend_q <= gnt_o && !dec_hit;
    end
  end

  a_req_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(tgt_req_o));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CntW'(MaxTrans));
  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rvalid_o && (cnt_q == '0)));
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                           $stable(be_i) && $stable(wdata_i)));

endmodule
